// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared encodings for the multicycle MIPS controller:
//                FSM state enum, ALU operation codes, opcode/funct values
//                and small decode helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4
    } alu_op_e;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    // R-type funct codes the datapath supports
    function automatic logic funct_ok(input logic [5:0] f);
        return (f == c_FN_ADD) || (f == c_FN_SUB) || (f == c_FN_AND) ||
               (f == c_FN_OR)  || (f == c_FN_SLT);
    endfunction

    function automatic alu_op_e funct_to_alu(input logic [5:0] f);
        alu_op_e op;
        case (f)
            c_FN_SUB: op = ALU_SUB;
            c_FN_AND: op = ALU_AND;
            c_FN_OR:  op = ALU_OR;
            c_FN_SLT: op = ALU_SLT;
            default:  op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mc_wait_timer
//  Description : Memory-wait watchdog. Counts enabled cycles since the last
//                clear; expired is high in the cycle whose wait would make
//                the count reach TIMEOUT_CYCLES.
//  Ports       : clk, rst (sync, active-high), clear, enable -> expired
//  Revision    : 1.0  initial release
// ============================================================================
module mc_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    import mips_pkg::*;

    localparam int c_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_W-1:0] count_q;
    logic [c_W-1:0] count_d;

    // Expiry is flagged on the last permitted waiting cycle so the FSM
    // lands in FAULT exactly one cycle after the count reaches the limit.
    assign expired = enable && !clear && (count_q == c_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + c_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/FAULT)
//                with memory-wait timeout and optional retire counter.
//  Ports       : clk, rst (sync, active-high); opcode, funct, zero,
//                mem_ready in; memory, PC, ALU and register-file strobes,
//                state, fault, retired, retire_count out.
//  Config      : define MULTICYCLE_CTRL_PERF_EN to enable retire_count.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic        reg_dst,
    output logic        mem2reg,
    output logic        reg_write,
    output logic [2:0]  state,
    output logic        fault,
    output logic        retired,
    output logic [31:0] retire_count
);
    import mips_pkg::*;

    state_e state_q;
    state_e state_d;
    logic   w_waiting;
    logic   w_expired;
    logic   w_is_r;

    assign w_waiting = (state_q == S_FETCH) || (state_q == S_MEM);
    assign w_is_r    = (opcode == c_OP_RTYPE);
    assign state     = state_q;

    // Outside FETCH/MEM the counter is held at zero, so entering a wait
    // state always starts from a clean count.
    mc_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!w_waiting || mem_ready),
        .enable  (w_waiting),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_op    = ALU_ADD;
        reg_dst   = 1'b0;
        mem2reg   = 1'b0;
        reg_write = 1'b0;
        fault     = 1'b0;
        retired   = 1'b0;

        // Reset silences every strobe in the cycle it is asserted.
        if (rst) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'd1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (w_expired) begin
                        state_d = S_FAULT;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'd3;
                    if (opcode == c_OP_J) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                        retired  = 1'b1;
                        state_d  = S_FETCH;
                    end else if ((w_is_r && funct_ok(funct)) || opcode == c_OP_ADDI ||
                                 opcode == c_OP_LW || opcode == c_OP_SW ||
                                 opcode == c_OP_BEQ) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    case (opcode)
                        c_OP_RTYPE: begin
                            alu_op  = funct_to_alu(funct);
                            state_d = S_WB;
                        end
                        c_OP_ADDI: begin
                            alu_src_b = 2'd2;
                            state_d   = S_WB;
                        end
                        c_OP_LW, c_OP_SW: begin
                            alu_src_b = 2'd2;
                            state_d   = S_MEM;
                        end
                        c_OP_BEQ: begin
                            alu_op   = ALU_SUB;
                            pc_src   = 2'd1;
                            pc_write = zero;
                            retired  = 1'b1;
                            state_d  = S_FETCH;
                        end
                        default: state_d = S_FAULT;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (opcode == c_OP_SW);
                    if (mem_ready) begin
                        if (opcode == c_OP_LW) begin
                            state_d = S_WB;
                        end else if (opcode == c_OP_SW) begin
                            retired = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_FAULT;
                        end
                    end else if (w_expired) begin
                        state_d = S_FAULT;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = w_is_r;
                    mem2reg   = (opcode == c_OP_LW);
                    retired   = 1'b1;
                    state_d   = S_FETCH;
                end
                S_FAULT: begin
                    fault = 1'b1;
                end
                default: begin
                    state_d = S_FAULT;
                end
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] retire_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_count_q <= '0;
        end else if (retired) begin
            retire_count_q <= retire_count_q + 32'd1;
        end
    end

    assign retire_count = retire_count_q;
`else
    assign retire_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl. Random instruction
//                stream with random memory wait states, checked per cycle
//                against an instruction-level reference model, plus
//                directed timeout, illegal-opcode and mid-MEM reset cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic        reg_dst, mem2reg, reg_write;
    logic [2:0]  state;
    logic        fault, retired;
    logic [31:0] retire_count;

    multicycle_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_dst(reg_dst), .mem2reg(mem2reg), .reg_write(reg_write),
        .state(state), .fault(fault), .retired(retired),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       flt;
        logic       req;
        logic       we;
        logic       iord;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic       asa;
        logic [1:0] asb;
        logic [3:0] aop;
        logic       rdst;
        logic       m2r;
        logic       rw;
        logic       ret;
    } obs_t;

    obs_t obs;
    assign obs = {state, fault, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_dst, mem2reg, reg_write, retired};

    int total = 0;
    int bad = 0;
    int model_cnt = 0;
    int cyc = 0;
    int ret_cnt = 0;
    int ret_at = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then compare.
    task automatic step(input string tag, input obs_t e, input logic rdy,
                        input logic [5:0] op, input logic [5:0] fn, input logic rs);
        @(negedge clk);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check("retire_count", retire_count, 32'(model_cnt));
`else
        check("retire_count", retire_count, 32'd0);
`endif
        rst = rs; mem_ready = rdy; opcode = op; funct = fn;
        #1;
        check(tag, obs, e);
        cyc++;
        if (obs.ret) begin
            ret_cnt++;
            ret_at = cyc;
        end
        if (e.ret) model_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("reset", obs, 32'd0);
        model_cnt = 0;
    endtask

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h22: return 4'd1;
            6'h24: return 4'd2;
            6'h25: return 4'd3;
            6'h2A: return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wf, input int wm, input int rstk, output bit aborted);
        obs_t e;
        logic rdy;
        bit is_r, valid, is_mem;
        is_r   = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                                   fn == 6'h25 || fn == 6'h2A);
        valid  = is_r || op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04;
        is_mem = (op == 6'h23 || op == 6'h2B);
        aborted = 1'b0;
        zero = z;
        for (int k = 0; k <= wf; k++) begin
            e = '0;
            if (k == TIMEOUT) begin
                e.st = 3'd5; e.flt = 1'b1;
                step("fetch_timeout", e, 1'b0, 6'($urandom), 6'($urandom), 1'b0);
                aborted = 1'b1;
                return;
            end
            rdy = (k == wf);
            e.st = 3'd0; e.req = 1'b1; e.asb = 2'd1;
            e.irw = rdy; e.pcw = rdy;
            // IR is not yet loaded: the opcode bus carries garbage here
            step("fetch", e, rdy, 6'($urandom), 6'($urandom), 1'b0);
        end
        e = '0; e.st = 3'd1; e.asb = 2'd3;
        if (op == 6'h02) begin
            e.pcw = 1'b1; e.pcs = 2'd2; e.ret = 1'b1;
        end
        step("decode", e, 1'($urandom), op, fn, 1'b0);
        if (op == 6'h02) return;
        if (!valid) begin
            e = '0; e.st = 3'd5; e.flt = 1'b1;
            for (int k = 0; k < 3; k++) step("fault_hold", e, 1'($urandom), op, fn, 1'b0);
            aborted = 1'b1;
            return;
        end
        e = '0; e.st = 3'd2; e.asa = 1'b1;
        if (op == 6'h04) begin
            e.aop = 4'd1; e.pcs = 2'd1; e.pcw = z; e.ret = 1'b1;
        end else if (is_r) begin
            e.aop = alu_of(fn);
        end else begin
            e.asb = 2'd2;
        end
        step("exec", e, 1'($urandom), op, fn, 1'b0);
        if (op == 6'h04) return;
        if (is_mem) begin
            for (int k = 0; k <= wm; k++) begin
                e = '0;
                if (k == rstk) begin
                    e.st = 3'd3;
                    step("rst_mid_mem", e, 1'b1, op, fn, 1'b1);
                    aborted = 1'b1;
                    return;
                end
                if (k == TIMEOUT) begin
                    e.st = 3'd5; e.flt = 1'b1;
                    step("mem_timeout", e, 1'b0, op, fn, 1'b0);
                    aborted = 1'b1;
                    return;
                end
                rdy = (k == wm);
                e.st = 3'd3; e.req = 1'b1; e.iord = 1'b1; e.we = (op == 6'h2B);
                e.ret = rdy && (op == 6'h2B);
                step("mem", e, rdy, op, fn, 1'b0);
            end
            if (op == 6'h2B) return;
        end
        e = '0; e.st = 3'd4; e.rw = 1'b1; e.rdst = is_r; e.m2r = (op == 6'h23); e.ret = 1'b1;
        step("wb", e, 1'($urandom), op, fn, 1'b0);
    endtask

    // Runs one instruction and checks retire count and latency from FETCH entry.
    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int wf, input int wm, input int rstk);
        bit ab;
        int lat;
        cyc = 0; ret_cnt = 0; ret_at = 0;
        run_instr(op, fn, z, wf, wm, rstk, ab);
        check("retire_pulses", 32'(ret_cnt), ab ? 32'd0 : 32'd1);
        if (!ab) begin
            case (op)
                6'h02:   lat = 2;
                6'h04:   lat = 3;
                6'h23:   lat = 5 + wm;
                6'h2B:   lat = 4 + wm;
                default: lat = 4;
            endcase
            check("latency", 32'(ret_at), 32'(lat + wf));
        end
    endtask

    logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    logic [5:0] fns [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h11, 6'h05, 6'h3F, 6'h00, 6'h01};

    initial begin
        int sel;
        do_reset();
        // Directed: ADDI, LW with 3 wait states, BEQ taken and not taken
        instr(6'h08, 6'h05, 1'b0, 0, 0, -1);
        instr(6'h23, 6'h00, 1'b0, 0, 3, -1);
        instr(6'h04, 6'h00, 1'b1, 0, 0, -1);
        instr(6'h04, 6'h00, 1'b0, 0, 0, -1);
        for (int i = 0; i < 10; i++) instr(i % 2 ? 6'h08 : 6'h02, 6'h00, 1'b0, 0, 0, -1);
        // Random stream
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            instr(ops[sel], fns[sel], 1'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 3), -1);
        end
        // Reset in the middle of a store's memory wait
        instr(6'h2B, 6'h00, 1'b0, 1, 3, 1);
        instr(6'h08, 6'h00, 1'b0, 0, 0, -1);
        // Fetch timeout
        do_reset();
        instr(6'h08, 6'h00, 1'b0, 40, 0, -1);
        do_reset();
        // Memory timeout on a load
        instr(6'h23, 6'h00, 1'b0, 2, 40, -1);
        do_reset();
        // Illegal opcode and illegal R-type funct
        instr(6'h3F, 6'h20, 1'b0, 0, 0, -1);
        do_reset();
        instr(6'h00, 6'h3F, 1'b0, 1, 0, -1);
        do_reset();
        instr(6'h00, 6'h2A, 1'b0, 0, 0, -1);
        instr(6'h2B, 6'h00, 1'b0, 2, 2, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
